// File: rtl/hazard_unit_mc_if.sv
// Signal bundle between the pipeline datapath and the hazard unit.
// The pipeline drives stage indices and controls; the hazard unit returns stalls, flushes, forwards.
interface hazard_unit_mc_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic [REG_ADDR_W-1:0] rs1_e;
    logic [REG_ADDR_W-1:0] rs2_e;
    logic [REG_ADDR_W-1:0] rd_e;
    logic [1:0]            result_src_e;
    logic [1:0]            md_op_e;
    logic                  pc_src_e;
    logic                  reg_write_m;
    logic [REG_ADDR_W-1:0] rd_m;
    logic                  mem_access_m;
    logic                  reg_write_w;
    logic [REG_ADDR_W-1:0] rd_w;

    logic                  stall_f;
    logic                  stall_d;
    logic                  stall_e;
    logic                  stall_m;
    logic                  flush_d;
    logic                  flush_e;
    logic                  flush_m;
    logic                  flush_w;
    logic [1:0]            forward_a_e;
    logic [1:0]            forward_b_e;
    logic                  md_busy;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e, md_op_e, pc_src_e,
               reg_write_m, rd_m, mem_access_m, reg_write_w, rd_w,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
               forward_a_e, forward_b_e, md_busy
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e, md_op_e, pc_src_e,
               reg_write_m, rd_m, mem_access_m, reg_write_w, rd_w,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
               forward_a_e, forward_b_e, md_busy
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for a 5-stage RV32IM pipeline: forwarding, load-use, branch flush,
// plus sequencing for a multi-cycle MUL/DIV unit in EX and a wait-stated data memory in MEM.
module hazard_unit_mc #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MUL_CYCLES = 1,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned MEM_WAIT   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    hazard_unit_mc_if.slave hz
);

    localparam logic [REG_ADDR_W-1:0] RegZero  = '0;
    localparam logic [7:0]            MulN     = 8'(MUL_CYCLES);
    localparam logic [7:0]            DivN     = 8'(DIV_CYCLES);
    localparam logic [7:0]            MemLoad  = 8'(MEM_WAIT - 1);
    localparam logic                  MemWaitEn = (MEM_WAIT != 0);

    typedef enum logic [0:0] {MemIdle, MemWait} mem_state_e;
    typedef enum logic [1:0] {MdIdle, MdBusy, MdDone} md_state_e;

    mem_state_e mem_state_q, mem_state_d;
    md_state_e  md_state_q, md_state_d;
    logic [7:0] mem_cnt_q, mem_cnt_d;
    logic [7:0] md_cnt_q, md_cnt_d;

    logic [7:0] md_n;
    logic       md_start;
    logic       mem_stall;
    logic       md_stall;
    logic       stall_e;
    logic       lu;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  wr_m,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  wr_w,
        input logic [REG_ADDR_W-1:0] rd_w
    );
        if (rs == RegZero)             return 2'b00;
        if (wr_m && (rs == rd_m))      return 2'b10;
        if (wr_w && (rs == rd_w))      return 2'b01;
        return 2'b00;
    endfunction

    assign md_n     = (hz.md_op_e == 2'b01) ? MulN : DivN;
    assign md_start = (hz.md_op_e != 2'b00) && (md_n > 8'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_state_q <= MemIdle;
            mem_cnt_q   <= 8'd0;
            md_state_q  <= MdIdle;
            md_cnt_q    <= 8'd0;
        end else begin
            mem_state_q <= mem_state_d;
            mem_cnt_q   <= mem_cnt_d;
            md_state_q  <= md_state_d;
            md_cnt_q    <= md_cnt_d;
        end
    end

    always_comb begin
        mem_state_d = mem_state_q;
        mem_cnt_d   = mem_cnt_q;
        unique case (mem_state_q)
            MemIdle: begin
                if (hz.mem_access_m && MemWaitEn) begin
                    mem_state_d = MemWait;
                    mem_cnt_d   = MemLoad;
                end
            end
            MemWait: begin
                if (mem_cnt_q != 8'd0) mem_cnt_d   = mem_cnt_q - 8'd1;
                else                   mem_state_d = MemIdle;
            end
            default: mem_state_d = MemIdle;
        endcase

        md_state_d = md_state_q;
        md_cnt_d   = md_cnt_q;
        unique case (md_state_q)
            MdIdle: begin
                if (md_start) begin
                    md_state_d = MdBusy;
                    md_cnt_d   = md_n - 8'd2;
                end
            end
            // The counter runs even under a memory hold; a finished but held op parks in DONE.
            MdBusy: begin
                if (md_cnt_q != 8'd0) md_cnt_d   = md_cnt_q - 8'd1;
                else                  md_state_d = stall_e ? MdDone : MdIdle;
            end
            MdDone: begin
                if (!stall_e) md_state_d = MdIdle;
            end
            default: md_state_d = MdIdle;
        endcase
    end

    always_comb begin
        mem_stall = 1'b0;
        unique case (mem_state_q)
            MemIdle: mem_stall = hz.mem_access_m && MemWaitEn;
            MemWait: mem_stall = (mem_cnt_q != 8'd0);
            default: mem_stall = 1'b0;
        endcase

        md_stall = 1'b0;
        unique case (md_state_q)
            MdIdle:  md_stall = md_start;
            MdBusy:  md_stall = (md_cnt_q != 8'd0);
            MdDone:  md_stall = 1'b0;
            default: md_stall = 1'b0;
        endcase

        stall_e = mem_stall | md_stall;
        lu      = (hz.result_src_e == 2'b01) && (hz.rd_e != RegZero) &&
                  ((hz.rs1_d == hz.rd_e) || (hz.rs2_d == hz.rd_e));

        // Everything is forced quiet while reset is held.
        hz.stall_m     = rst_n & mem_stall;
        hz.flush_w     = rst_n & mem_stall;
        hz.stall_e     = rst_n & stall_e;
        hz.flush_m     = rst_n & md_stall & ~mem_stall;
        hz.stall_d     = rst_n & (stall_e | lu);
        hz.stall_f     = rst_n & (stall_e | lu);
        hz.flush_e     = rst_n & (lu | hz.pc_src_e) & ~stall_e;
        hz.flush_d     = rst_n & hz.pc_src_e & ~stall_e;
        hz.md_busy     = rst_n & (md_state_q != MdIdle);
        hz.forward_a_e = 2'b00;
        hz.forward_b_e = 2'b00;
        if (rst_n) begin
            hz.forward_a_e = fwd_sel(hz.rs1_e, hz.reg_write_m, hz.rd_m, hz.reg_write_w, hz.rd_w);
            hz.forward_b_e = fwd_sel(hz.rs2_e, hz.reg_write_m, hz.rd_m, hz.reg_write_w, hz.rd_w);
        end
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Multi-cycle-aware hazard unit for the 5-stage RV32IM pipeline: IF, ID, EX, MEM, WB.
- Keeps the existing hazard functions: EX-stage operand forwarding, load-use stall and branch flush.
- Adds sequencing for a multi-cycle MUL/DIV unit that occupies EX for a parametrised number of cycles.
- Adds sequencing for a data memory with parametrised wait states in MEM.
- Drives stall/flush enables of all four pipeline registers (F, D, E, M) plus the M→W bubble.

Parameters:
REG_ADDR_W, 5, register index width.
MUL_CYCLES, 1, total EX cycles of a MUL-class op (1..255; 1 = no stall).
DIV_CYCLES, 32, total EX cycles of a DIV/REM-class op (1..255).
MEM_WAIT, 0, extra wait cycles per data-memory access in MEM (0..255; 0 = no stall).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous, active-low reset.
rs1_d  in  REG_ADDR_W  ID source 1.
rs2_d  in  REG_ADDR_W  ID source 2.
rs1_e  in  REG_ADDR_W  EX source 1.
rs2_e  in  REG_ADDR_W  EX source 2.
rd_e  in  REG_ADDR_W  EX destination.
result_src_e  in  2  EX result select; 2'b01 = load.
md_op_e  in  2  EX MUL/DIV class: 00 none, 01 mul, 10 div, 11 rem (timed as div).
pc_src_e  in  1  EX branch/jump taken.
reg_write_m  in  1  MEM writes rd_m.
rd_m  in  REG_ADDR_W  MEM destination.
mem_access_m  in  1  MEM holds load/store.
reg_write_w  in  1  WB writes rd_w.
rd_w  in  REG_ADDR_W  WB destination.
stall_f, stall_d, stall_e, stall_m  out  1 each  hold pipeline register.
flush_d, flush_e, flush_m, flush_w  out  1 each  bubble into register.
forward_a_e, forward_b_e  out  2 each  00 regfile, 01 result_w, 10 alu_result_m.
md_busy  out  1  MUL/DIV FSM not IDLE.

Behaviour:
Reset and gating:
- Reset applies on a clock edge with rst_n=0: both FSMs go to IDLE and both counters go to 0.
- While rst_n=0, all stall/flush outputs are 0, forwards are 00 and md_busy is 0.

Forwarding:
- Combinational, per operand.
- Index 0 → 00.
- Else match rd_m && reg_write_m → 10.
- Else match rd_w && reg_write_w → 01.
- Else 00.

Load-use (lu):
- lu = result_src_e==01 && rd_e!=0 && (rs1_d==rd_e || rs2_d==rd_e).

Memory-wait FSM (states IDLE, WAIT; 8-bit counter):
- IDLE with mem_access_m and MEM_WAIT>0: mem_stall=1, load cnt=MEM_WAIT-1, go WAIT.
- WAIT: mem_stall=1 while cnt!=0; decrement each cycle.
- WAIT with cnt==0: mem_stall=0, go IDLE. The access completes and M advances.
- An access therefore spends exactly MEM_WAIT+1 cycles in MEM.
- Back-to-back accesses each pay the full wait.

MUL/DIV FSM (states IDLE, BUSY, DONE; 8-bit counter):
- N = MUL_CYCLES for md_op_e==01, else DIV_CYCLES.
- IDLE with md_op_e!=00 and N>1: md_stall=1, load cnt=N-2, go BUSY.
- IDLE with md_op_e!=00 and N==1: no stall, stay IDLE.
- BUSY: md_stall = (cnt!=0); cnt decrements every cycle, even while mem_stall holds the pipe.
- BUSY with cnt==0: go IDLE if stall_e==0, else go DONE.
- DONE: md_stall=0; stay while stall_e=1, return to IDLE when stall_e=0. This prevents a held, already-finished op from restarting.
- With no external hold, the op occupies EX exactly N cycles, stalled for the first N-1.

Output combination, in priority order:
- stall_m = flush_w = mem_stall.
- stall_e = mem_stall | md_stall.
- flush_m = md_stall & ~mem_stall.
- stall_d = stall_f = stall_e | lu.
- flush_e = (lu | pc_src_e) & ~stall_e.
- flush_d = pc_src_e & ~stall_e. A branch held in EX redirects when released.
- md_busy = (md_state != IDLE).

Test Plan:
1. Forwarding: rs1_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 → forward_a_e=10. Then rs1_e=0 with the same M/W state → 00. Then rs2_e=7, rd_w=7, reg_write_w=1 → forward_b_e=01.
2. Load-use: result_src_e=01, rd_e=3, rs2_d=3 for 1 cycle → stall_f=stall_d=flush_e=1 for that cycle, stall_e=0. With rd_e=0 and otherwise the same inputs → no stall.
3. DIV, DIV_CYCLES=4: md_op_e=10 held in EX → stall_e=stall_d=flush_m=1 for cycles 0-2, all 0 in cycle 3. md_busy=1 in cycles 1-3, 0 in cycle 4.
4. MEM_WAIT=2, mem_access_m=1 → stall_f/d/e/m=flush_w=1 for 2 cycles, then 0 for 1 cycle. A back-to-back second access repeats the same pattern.
5. Overlap, DIV_CYCLES=3, MEM_WAIT=3, div enters EX with an access in MEM in the same cycle → stall_e=1 for 3 cycles. FSM goes BUSY→DONE, holds DONE one cycle, then IDLE. The div is not restarted (md_busy=0 after release), and flush_m=0 throughout.
6. pc_src_e=1 while mem_stall=1 → flush_d=flush_e=0. On the release cycle flush_d=flush_e=1. Reset asserted mid-BUSY → next cycle md_busy=0 and all outputs 0.
